// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads the two 16-bit words named by a pointer pair and
// presents them as one 32-bit instruction, reusing the low word on sequential flow.
module fetch_unit #(
  parameter logic [15:0] RESET_PTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pointer,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pointer,
  output logic        instr_valid,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {FETCH_HI, FETCH_LO, VALID} state_t;

  state_t      state_reg, state_next;
  logic        mem_req_reg, mem_req_next;
  logic [15:0] mem_addr_reg, mem_addr_next;
  logic [31:0] instruction_reg, instruction_next;
  logic [31:0] instr_pointer_reg, instr_pointer_next;
  logic        instr_valid_reg, instr_valid_next;
  logic        lo_cache_valid_reg, lo_cache_valid_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= FETCH_HI;
      mem_req_reg        <= 1'b0;
      mem_addr_reg       <= 16'h0000;
      instruction_reg    <= 32'h0000_0000;
      instr_pointer_reg  <= {RESET_PTR, RESET_PTR + 16'h0001};
      instr_valid_reg    <= 1'b0;
      lo_cache_valid_reg <= 1'b0;
    end else begin
      state_reg          <= state_next;
      mem_req_reg        <= mem_req_next;
      mem_addr_reg       <= mem_addr_next;
      instruction_reg    <= instruction_next;
      instr_pointer_reg  <= instr_pointer_next;
      instr_valid_reg    <= instr_valid_next;
      lo_cache_valid_reg <= lo_cache_valid_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    mem_req_next        = mem_req_reg;
    mem_addr_next       = mem_addr_reg;
    instruction_next    = instruction_reg;
    instr_pointer_next  = instr_pointer_reg;
    instr_valid_next    = instr_valid_reg;
    lo_cache_valid_next = lo_cache_valid_reg;

    case (state_reg)
      FETCH_HI: begin
        // Only reached idle right after reset; otherwise the request was issued on accept.
        if (!mem_req_reg) begin
          mem_req_next  = 1'b1;
          mem_addr_next = instr_pointer_reg[31:16];
        end else if (mem_ack) begin
          instruction_next[31:16] = mem_rdata;
          mem_addr_next           = instr_pointer_reg[15:0];
          state_next              = FETCH_LO;
        end
      end
      FETCH_LO: begin
        if (!mem_req_reg) begin
          mem_req_next  = 1'b1;
          mem_addr_next = instr_pointer_reg[15:0];
        end else if (mem_ack) begin
          instruction_next[15:0] = mem_rdata;
          mem_req_next           = 1'b0;
          instr_valid_next       = 1'b1;
          lo_cache_valid_next    = 1'b1;
          state_next             = VALID;
        end
      end
      VALID: begin
        if (instr_ready) begin
          instr_pointer_next  = next_pointer;
          instr_valid_next    = 1'b0;
          lo_cache_valid_next = 1'b0;
          mem_req_next        = 1'b1;
          // Next instruction begins at the word we already hold: shift it up, fetch one.
          if (lo_cache_valid_reg && (next_pointer[31:16] == instr_pointer_reg[15:0])) begin
            instruction_next[31:16] = instruction_reg[15:0];
            mem_addr_next           = next_pointer[15:0];
            state_next              = FETCH_LO;
          end else begin
            mem_addr_next = next_pointer[31:16];
            state_next    = FETCH_HI;
          end
        end
      end
      default: begin
        state_next   = FETCH_HI;
        mem_req_next = 1'b0;
      end
    endcase
  end

  assign instruction   = instruction_reg;
  assign instr_pointer = instr_pointer_reg;
  assign instr_valid   = instr_valid_reg;
  assign mem_req       = mem_req_reg;
  assign mem_addr      = mem_addr_reg;

endmodule
